// File: rtl/matrix_uart_printer.sv
// Streams an R x C matrix snapshot to a UART TX as right-aligned decimal text, one line per row.
// Define MATRIX_PRINTER_CRLF_EN to end lines with CR LF instead of LF alone.
module matrix_uart_printer #(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 5,
  parameter int DIM_W   = 3,
  parameter int SIGNED  = 0,
  parameter int FIELD_W = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [DIM_W-1:0]                  mat_rows,
  input  logic [DIM_W-1:0]                  mat_cols,
  input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] data_flat,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [7:0]                        tx_data,
  output logic                              tx_start,
  input  logic                              tx_busy
);
  localparam int NDIG = (DATA_W * 77) / 256 + 1;
  localparam int NW   = $clog2(NDIG + 1);
  localparam int KW   = $clog2(MAX_DIM * MAX_DIM + 1);
  localparam int BW   = $clog2(DATA_W);
  localparam int PW   = $clog2(FIELD_W + 2);
  localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(MAX_DIM);

  typedef enum logic [3:0] {
    IDLE, LOAD, CONV, PAD, SIGN, DIGIT, SEP, DONE, WAIT_REL
  } state_t;

  state_t                            state;
  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] data_q;
  logic [DIM_W-1:0]                  rows_q, cols_q, r, c;
  logic [KW-1:0]                     k;
  logic                              neg, guard;
  logic [DATA_W-1:0]                 q, q_nxt, elem;
  logic [3:0]                        rem, rem_nxt;
  logic [4:0]                        trial;
  logic [BW-1:0]                     bitcnt;
  logic [NW-1:0]                     ndig;
  logic [PW-1:0]                     pad_cnt;
  logic [3:0]                        dbuf [NDIG];
  logic                              dims_bad, tx_ready, last_col, last_row;
  int                                len_i, pad_i;
`ifdef MATRIX_PRINTER_CRLF_EN
  logic                              lf_pend;
`endif

  assign elem     = data_q[int'(k)*DATA_W +: DATA_W];
  assign dims_bad = (mat_rows == '0) || (mat_rows > DIM_MAX) ||
                    (mat_cols == '0) || (mat_cols > DIM_MAX);
  // The guard cycle after each strobe lets the UART raise tx_busy before we look at it.
  assign tx_ready = !guard && !tx_busy;
  assign last_col = (c == cols_q - DIM_W'(1));
  assign last_row = (r == rows_q - DIM_W'(1));

  // One restoring step: shift the next dividend bit into the remainder, subtract 10 if it fits.
  always_comb begin
    trial = {rem, q[DATA_W-1]};
    if (trial >= 5'd10) begin
      rem_nxt = 4'(trial - 5'd10);
      q_nxt   = {q[DATA_W-2:0], 1'b1};
    end else begin
      rem_nxt = trial[3:0];
      q_nxt   = {q[DATA_W-2:0], 1'b0};
    end
  end

  // Printed length once the digit produced this cycle is counted.
  always_comb begin
    len_i = int'(ndig) + int'(neg) + 1;
    pad_i = (FIELD_W > len_i) ? (FIELD_W - len_i) : 0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      guard    <= 1'b0;
      data_q   <= '0;
      rows_q   <= '0;
      cols_q   <= '0;
      r        <= '0;
      c        <= '0;
      k        <= '0;
      neg      <= 1'b0;
      q        <= '0;
      rem      <= '0;
      bitcnt   <= '0;
      ndig     <= '0;
      pad_cnt  <= '0;
      for (int i = 0; i < NDIG; i++) dbuf[i] <= '0;
`ifdef MATRIX_PRINTER_CRLF_EN
      lf_pend  <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      tx_start <= 1'b0;
      guard    <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (dims_bad) begin
            err <= 1'b1;
          end else begin
            data_q <= data_flat;
            rows_q <= mat_rows;
            cols_q <= mat_cols;
            r      <= '0;
            c      <= '0;
            k      <= '0;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (SIGNED != 0 && elem[DATA_W-1]) begin
            neg <= 1'b1;
            q   <= DATA_W'(0) - elem;
          end else begin
            neg <= 1'b0;
            q   <= elem;
          end
          rem    <= '0;
          bitcnt <= '0;
          ndig   <= '0;
          state  <= CONV;
        end
        CONV: begin
          if (bitcnt == BW'(DATA_W - 1)) begin
            dbuf[ndig] <= rem_nxt;
            ndig       <= ndig + 1'b1;
            if (q_nxt == '0) begin
              pad_cnt <= PW'(pad_i);
              state   <= PAD;
            end else begin
              q      <= q_nxt;
              rem    <= '0;
              bitcnt <= '0;
            end
          end else begin
            q      <= q_nxt;
            rem    <= rem_nxt;
            bitcnt <= bitcnt + 1'b1;
          end
        end
        PAD: begin
          if (pad_cnt == '0) begin
            state <= SIGN;
          end else if (tx_ready) begin
            tx_data  <= 8'h20;
            tx_start <= 1'b1;
            guard    <= 1'b1;
            pad_cnt  <= pad_cnt - 1'b1;
          end
        end
        SIGN: begin
          if (!neg) begin
            state <= DIGIT;
          end else if (tx_ready) begin
            tx_data  <= 8'h2D;
            tx_start <= 1'b1;
            guard    <= 1'b1;
            state    <= DIGIT;
          end
        end
        DIGIT: if (tx_ready) begin
          tx_data  <= 8'h30 + {4'h0, dbuf[ndig - 1'b1]};
          tx_start <= 1'b1;
          guard    <= 1'b1;
          ndig     <= ndig - 1'b1;
          if (ndig == NW'(1)) state <= SEP;
        end
        SEP: if (tx_ready) begin
          tx_start <= 1'b1;
          guard    <= 1'b1;
          if (!last_col) begin
            tx_data <= 8'h20;
            c       <= c + 1'b1;
            k       <= k + 1'b1;
            state   <= LOAD;
          end else begin
`ifdef MATRIX_PRINTER_CRLF_EN
            if (!lf_pend) begin
              tx_data <= 8'h0D;
              lf_pend <= 1'b1;
            end else begin
              tx_data <= 8'h0A;
              lf_pend <= 1'b0;
              if (last_row) begin
                state <= DONE;
              end else begin
                r     <= r + 1'b1;
                c     <= '0;
                k     <= k + 1'b1;
                state <= LOAD;
              end
            end
`else
            tx_data <= 8'h0A;
            if (last_row) begin
              state <= DONE;
            end else begin
              r     <= r + 1'b1;
              c     <= '0;
              k     <= k + 1'b1;
              state <= LOAD;
            end
`endif
          end
        end
        DONE: if (tx_ready) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= WAIT_REL;
        end
        WAIT_REL: if (!start) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_uart_printer.sv
// Directed bench for matrix_uart_printer: unsigned and signed/padded instances share clock, reset and data.
module tb_matrix_uart_printer;
  localparam int BUSY_LEN = 3;
  localparam int BUDGET   = 5000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, start_s = 1'b0;
  logic [2:0]   mat_rows = '0, mat_cols = '0;
  logic [199:0] data_flat = '0;
  logic         busy, done, err, tx_start;
  logic         busy_s, done_s, err_s, tx_start_s;
  logic [7:0]   tx_data, tx_data_s;
  logic         tx_busy = 1'b0, tx_busy_s = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] got_s_q[$];
  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0, done_s_cnt = 0, err_s_cnt = 0;
  int bcnt = 0, bcnt_s = 0;

  matrix_uart_printer #(.DATA_W(8), .MAX_DIM(5), .DIM_W(3), .SIGNED(0), .FIELD_W(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mat_rows(mat_rows), .mat_cols(mat_cols),
    .data_flat(data_flat), .busy(busy), .done(done), .err(err), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy));

  matrix_uart_printer #(.DATA_W(8), .MAX_DIM(5), .DIM_W(3), .SIGNED(1), .FIELD_W(4)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .mat_rows(mat_rows), .mat_cols(mat_cols),
    .data_flat(data_flat), .busy(busy_s), .done(done_s), .err(err_s), .tx_data(tx_data_s),
    .tx_start(tx_start_s), .tx_busy(tx_busy_s));

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // UART models: capture each strobe, then stay busy for BUSY_LEN cycles
  always @(negedge clk) begin
    if (tx_start) begin
      got_q.push_back(tx_data);
      tx_busy = 1'b1;
      bcnt = BUSY_LEN;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) tx_busy = 1'b0;
    end
    if (tx_start_s) begin
      got_s_q.push_back(tx_data_s);
      tx_busy_s = 1'b1;
      bcnt_s = BUSY_LEN;
    end else if (bcnt_s > 0) begin
      bcnt_s--;
      if (bcnt_s == 0) tx_busy_s = 1'b0;
    end
    if (done)   done_cnt++;
    if (err)    err_cnt++;
    if (done_s) done_s_cnt++;
    if (err_s)  err_s_cnt++;
  end

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input bit sel);
    int n;
    n = sel ? got_s_q.size() : got_q.size();
    check({tag, "_len"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check(tag, sel ? got_s_q[i] : got_q[i], exp_q[i]);
  endtask

  task automatic push_term();
`ifdef MATRIX_PRINTER_CRLF_EN
    exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(8'h0A);
  endtask

  // drivers
  task automatic set_elem(input int k, input logic [7:0] v);
    data_flat[k*8 +: 8] = v;
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start_s = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_s = 1'b0;
  endtask

  task automatic wait_done(input bit sel);
    int d0, n;
    d0 = sel ? done_s_cnt : done_cnt;
    n = 0;
    while ((sel ? done_s_cnt : done_cnt) == d0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(n < BUDGET), 32'd1);
  endtask

  task automatic load_2x2();
    data_flat = '0;
    set_elem(0, 8'd0);
    set_elem(1, 8'd7);
    set_elem(2, 8'd10);
    set_elem(3, 8'd255);
    mat_rows = 3'd2;
    mat_cols = 3'd2;
    exp_q = '{8'h30, 8'h20, 8'h37};
    push_term();
    exp_q.push_back(8'h31); exp_q.push_back(8'h30); exp_q.push_back(8'h20);
    exp_q.push_back(8'h32); exp_q.push_back(8'h35); exp_q.push_back(8'h35);
    push_term();
  endtask

  task automatic run_2x2(input string tag);
    int d0, e0;
    load_2x2();
    got_q.delete();
    d0 = done_cnt;
    e0 = err_cnt;
    pulse_start(1'b0);
    check({tag, "_busy_acc"}, busy, 1);
    wait_done(1'b0);
    check({tag, "_busy_end"}, busy, 0);
    repeat (4) @(negedge clk);
    check({tag, "_done_cnt"}, done_cnt - d0, 1);
    check({tag, "_err_cnt"}, err_cnt - e0, 0);
    check_bytes(tag, 1'b0);
  endtask

  initial begin
    int d0, e0, n;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // unsigned 2x2 with multi-digit values and zero
    run_2x2("t1");

    // signed, field width 4: -128 fills the field, 5 gets three pad spaces
    data_flat = '0;
    set_elem(0, 8'h80);
    set_elem(1, 8'h05);
    mat_rows = 3'd1;
    mat_cols = 3'd2;
    exp_q = '{8'h2D, 8'h31, 8'h32, 8'h38, 8'h20, 8'h20, 8'h20, 8'h20, 8'h35};
    push_term();
    got_s_q.delete();
    pulse_start(1'b1);
    wait_done(1'b1);
    check("t2_err_cnt", err_s_cnt, 0);
    check_bytes("t2", 1'b1);

    // rejected dimensions
    got_q.delete();
    e0 = err_cnt;
    mat_rows = 3'd0;
    mat_cols = 3'd2;
    pulse_start(1'b0);
    repeat (3) @(negedge clk);
    check("t3_err_rows0", err_cnt - e0, 1);
    check("t3_busy_rows0", busy, 0);
    mat_rows = 3'd1;
    mat_cols = 3'd6;
    pulse_start(1'b0);
    repeat (3) @(negedge clk);
    check("t3_err_cols6", err_cnt - e0, 2);
    check("t3_busy_cols6", busy, 0);
    check("t3_no_tx", got_q.size(), 0);

    // held start prints once, a fresh rising start prints again
    data_flat = '0;
    set_elem(0, 8'd9);
    mat_rows = 3'd1;
    mat_cols = 3'd1;
    exp_q = '{8'h39};
    push_term();
    got_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    repeat (200) @(negedge clk);
    start = 1'b0;
    check("t4_done_held", done_cnt - d0, 1);
    check_bytes("t4", 1'b0);
    repeat (3) @(negedge clk);
    got_q.delete();
    pulse_start(1'b0);
    wait_done(1'b0);
    check("t4_done_retrig", done_cnt - d0, 2);
    check_bytes("t4r", 1'b0);

    // reset after the third byte aborts the print
    load_2x2();
    got_q.delete();
    pulse_start(1'b0);
    n = 0;
    while (got_q.size() < 3 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("t5_three_bytes", 32'(n < BUDGET), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_tx_start", tx_start, 0);
    check("t5_rst_tx_data", tx_data, 8'h00);
    check("t5_rst_done", done, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("t5_no_more_tx", got_q.size(), 3);
    check("t5_idle_busy", busy, 0);
    repeat (10) @(negedge clk);
    run_2x2("t5");

    // single-digit line terminator
    data_flat = '0;
    set_elem(0, 8'd3);
    mat_rows = 3'd1;
    mat_cols = 3'd1;
    exp_q = '{8'h33};
    push_term();
    got_q.delete();
    pulse_start(1'b0);
    wait_done(1'b0);
    check_bytes("t6", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
